// File: rtl/axis_proc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_proc_pkg
// Description : Shared mode encodings and packet FSM states for the
//               AXI-Stream processing stage.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_proc_pkg;

  // Operation select values driven by the control block
  localparam logic [1:0] MODE_PASS   = 2'd0;
  localparam logic [1:0] MODE_ADD    = 2'd1;
  localparam logic [1:0] MODE_INV    = 2'd2;
  localparam logic [1:0] MODE_SATADD = 2'd3;

  // Packet tracking: IDLE means the next accepted beat starts a packet
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } pkt_state_t;

endpackage : axis_proc_pkg
`default_nettype wire

// File: rtl/axis_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : axis_skid_buf
// Description : Registered stream output stage with a one-entry skid buffer.
//               s_ready is a flop output (no path from m_ready), and one beat
//               of slack absorbs the cycle in which m_ready drops.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_skid_buf #(
  parameter int WIDTH = 33
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_skid_data;
  logic             w_in_accept;
  logic             w_out_free;

  // Ready is taken directly from the skid flop, so it is registered by construction
  assign s_ready     = ~r_skid_valid;
  assign w_in_accept = s_valid & ~r_skid_valid;
  // Output register can take a new beat when empty or being drained this cycle
  assign w_out_free  = ~r_out_valid | m_ready;

  assign m_valid = r_out_valid;
  assign m_data  = r_out_data;

  // Output register and skid entry; skid always drains before new input lands
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        // Input is blocked while the skid is full, so nothing else arrives here
        r_out_valid  <= 1'b1;
        r_out_data   <= r_skid_data;
        r_skid_valid <= 1'b0;
      end else if (w_in_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= s_data;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_in_accept) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= s_data;
    end
  end

endmodule : axis_skid_buf
`default_nettype wire

// File: rtl/axis_stream_proc.sv
`default_nettype none
// ============================================================================
// Module      : axis_stream_proc
// Description : AXI-Stream transform stage (pass / add / invert / saturating
//               add). Mode and operand are frozen for the length of a packet.
//               Tracks completed packets and a sticky saturation flag.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_stream_proc
  import axis_proc_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] add_value,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  input  logic                  clr_stats,
  output logic [DATA_WIDTH-1:0] pkt_count,
  output logic                  sat_flag
);

  pkt_state_t            r_state;
  pkt_state_t            w_state_next;
  logic [1:0]            r_mode_q;
  logic [DATA_WIDTH-1:0] r_op_q;
  logic                  w_latch_ctrl;
  logic [1:0]            w_mode_eff;
  logic [DATA_WIDTH-1:0] w_op_eff;
  logic [DATA_WIDTH:0]   w_sum;
  logic [DATA_WIDTH-1:0] w_result;
  logic                  w_clamp;
  logic                  w_in_accept;
  logic                  w_out_xfer;
  logic [DATA_WIDTH:0]   w_buf_out;
  logic [DATA_WIDTH-1:0] r_pkt_count;
  logic                  r_sat_flag;

  assign w_in_accept = s_axis_tvalid & s_axis_tready;
  assign w_out_xfer  = m_axis_tvalid & m_axis_tready;

  // First beat of a packet sees the live controls; later beats the latched copy
  assign w_mode_eff = (r_state == ST_IDLE) ? mode      : r_mode_q;
  assign w_op_eff   = (r_state == ST_IDLE) ? add_value : r_op_q;

  // Packet state register
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) r_state <= ST_IDLE;
    else                r_state <= w_state_next;
  end

  // Next-state: track packet boundaries on accepted beats
  always_comb begin
    w_state_next = r_state;
    w_latch_ctrl = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_in_accept) begin
          w_latch_ctrl = 1'b1;
          if (!s_axis_tlast) w_state_next = ST_IN_PKT;
        end
      end
      ST_IN_PKT: begin
        if (w_in_accept && s_axis_tlast) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Capture controls at packet start so register writes cannot tear a packet
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_mode_q <= MODE_PASS;
      r_op_q   <= '0;
    end else if (w_latch_ctrl) begin
      r_mode_q <= mode;
      r_op_q   <= add_value;
    end
  end

  // Beat transform; w_clamp marks a saturated mode-3 result
  always_comb begin
    w_sum    = {1'b0, s_axis_tdata} + {1'b0, w_op_eff};
    w_result = s_axis_tdata;
    w_clamp  = 1'b0;
    case (w_mode_eff)
      MODE_PASS:   w_result = s_axis_tdata;
      MODE_ADD:    w_result = w_sum[DATA_WIDTH-1:0];
      MODE_INV:    w_result = ~s_axis_tdata;
      MODE_SATADD: begin
        w_clamp  = w_sum[DATA_WIDTH];
        w_result = w_clamp ? {DATA_WIDTH{1'b1}} : w_sum[DATA_WIDTH-1:0];
      end
      default:     w_result = s_axis_tdata;
    endcase
  end

  axis_skid_buf #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_skid (
    .aclk    (s_axi_aclk),
    .aresetn (s_axi_aresetn),
    .s_valid (s_axis_tvalid),
    .s_ready (s_axis_tready),
    .s_data  ({s_axis_tlast, w_result}),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready),
    .m_data  (w_buf_out)
  );

  assign m_axis_tlast = w_buf_out[DATA_WIDTH];
  assign m_axis_tdata = w_buf_out[DATA_WIDTH-1:0];

  // Statistics: clear has priority over a same-cycle increment or set
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_pkt_count <= '0;
      r_sat_flag  <= 1'b0;
    end else if (clr_stats) begin
      r_pkt_count <= '0;
      r_sat_flag  <= 1'b0;
    end else begin
      if (w_out_xfer && m_axis_tlast) r_pkt_count <= r_pkt_count + 1'b1;
      if (w_in_accept && w_clamp)     r_sat_flag  <= 1'b1;
    end
  end

  assign pkt_count = r_pkt_count;
  assign sat_flag  = r_sat_flag;

endmodule : axis_stream_proc
`default_nettype wire

// File: tb/tb_axis_stream_proc.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_stream_proc
// Description : Scoreboard bench for axis_stream_proc. Drivers push the
//               hand-computed expected beat when it is accepted; a monitor
//               pops and compares on every output transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_stream_proc;

  localparam int DW = 32;

  logic          s_axi_aclk = 1'b0;
  logic          s_axi_aresetn = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [DW-1:0] add_value = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tlast = 1'b0;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic          clr_stats = 1'b0;
  logic [DW-1:0] pkt_count;
  logic          sat_flag;

  int total = 0;
  int bad   = 0;

  logic [DW:0] exp_q[$];      // {tlast, tdata}
  logic        prev_stall = 1'b0;
  logic [DW:0] held_beat  = '0;
  int          saw_stall_ready_low = 0;

  always #5 s_axi_aclk = ~s_axi_aclk;

  axis_stream_proc #(.DATA_WIDTH(DW)) dut (
    .s_axi_aclk    (s_axi_aclk),
    .s_axi_aresetn (s_axi_aresetn),
    .mode          (mode),
    .add_value     (add_value),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .clr_stats     (clr_stats),
    .pkt_count     (pkt_count),
    .sat_flag      (sat_flag)
  );

  task automatic check(input string name, input logic [DW:0] act, input logic [DW:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: at the falling edge, a valid&&ready pair will transfer at the next rise
  always @(negedge s_axi_aclk) begin
    if (prev_stall && m_axis_tvalid)
      check("hold_stable", {m_axis_tlast, m_axis_tdata}, held_beat);
    if (m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got 0x%0h expected none", m_axis_tdata);
      end else begin
        check("out_beat", {m_axis_tlast, m_axis_tdata}, exp_q.pop_front());
      end
    end
    if (!s_axis_tready) begin
      saw_stall_ready_low++;
      check("ready_low_implies_full", {{DW{1'b0}}, m_axis_tvalid}, {{DW{1'b0}}, 1'b1});
    end
    prev_stall = m_axis_tvalid && !m_axis_tready;
    held_beat  = {m_axis_tlast, m_axis_tdata};
  end

  // Offer one beat until accepted; returns 1ns after the accepting edge
  task automatic send(input logic [DW-1:0] d, input logic l, input logic [DW-1:0] ed);
    int budget;
    budget = 200;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    while (budget > 0) begin
      @(negedge s_axi_aclk);
      if (s_axis_tready) begin
        exp_q.push_back({l, ed});
        @(posedge s_axi_aclk);
        #1;
        break;
      end
      budget--;
    end
    if (budget == 0) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got stalled expected accept of 0x%0h", d);
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 200;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge s_axi_aclk);
      budget--;
    end
    @(posedge s_axi_aclk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic tick();
    @(posedge s_axi_aclk);
    #1;
  endtask

  initial begin
    logic [3:0] rdy_pat;
    rdy_pat = 4'b1001;   // bit k = ready in cycle k: 1,0,0,1

    repeat (3) @(posedge s_axi_aclk);
    #1;
    // Reset state, sampled while reset is still asserted
    check("rst_m_tvalid", {32'd0, m_axis_tvalid}, 33'd0);
    check("rst_m_tdata",  {1'b0, m_axis_tdata},  33'd0);
    check("rst_m_tlast",  {32'd0, m_axis_tlast},  33'd0);
    check("rst_s_tready", {32'd0, s_axis_tready}, 33'd1);
    check("rst_pkt_count", {1'b0, pkt_count}, 33'd0);
    check("rst_sat_flag", {32'd0, sat_flag}, 33'd0);
    s_axi_aresetn = 1'b1;
    tick();

    // Mode 0, 4-beat packet; first output valid one cycle after accept
    mode = 2'd0;
    send(32'h1, 1'b0, 32'h1);
    check("latency_valid", {32'd0, m_axis_tvalid}, 33'd1);
    check("latency_data",  {1'b0, m_axis_tdata},  {1'b0, 32'h1});
    send(32'h2, 1'b0, 32'h2);
    send(32'h3, 1'b0, 32'h3);
    send(32'h4, 1'b1, 32'h4);
    drain();
    check("pass_pkt_count", {1'b0, pkt_count}, 33'd1);

    // Mode 1 wraps with no flag; mode 3 clamps and flags
    mode = 2'd1; add_value = 32'h10;
    send(32'hFFFF_FFF8, 1'b1, 32'h0000_0008);
    drain();
    check("add_no_sat", {32'd0, sat_flag}, 33'd0);
    mode = 2'd3;
    send(32'hFFFF_FFF8, 1'b1, 32'hFFFF_FFFF);
    drain();
    check("satadd_flag", {32'd0, sat_flag}, 33'd1);

    // Mode switch inside a packet applies only to the next packet
    mode = 2'd2;
    send(32'h0F0F_0F0F, 1'b0, 32'hF0F0_F0F0);
    mode = 2'd0;
    send(32'h0F0F_0F0F, 1'b0, 32'hF0F0_F0F0);
    send(32'h0F0F_0F0F, 1'b1, 32'hF0F0_F0F0);
    send(32'h0F0F_0F0F, 1'b1, 32'h0F0F_0F0F);
    drain();
    check("midpkt_pkt_count", {1'b0, pkt_count}, 33'd5);

    // Backpressure: ready pattern 1,0,0,1 while 8 beats stream
    saw_stall_ready_low = 0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(32'hA0 + i, (i == 7), 32'hA0 + i);
      end
      begin
        for (int k = 0; k < 40; k++) begin
          m_axis_tready = rdy_pat[k % 4];
          tick();
        end
      end
    join
    m_axis_tready = 1'b1;
    drain();
    check("bp_skid_used", {32'd0, (saw_stall_ready_low > 0)}, 33'd1);
    check("bp_pkt_count", {1'b0, pkt_count}, 33'd6);

    // clr_stats coinciding with the tlast transfer that would make pkt_count 6
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check("clr_pkt_count", {1'b0, pkt_count}, 33'd0);
    for (int i = 0; i < 5; i++) send(32'h50 + i, 1'b1, 32'h50 + i);
    drain();
    check("five_pkts", {1'b0, pkt_count}, 33'd5);
    m_axis_tready = 1'b0;
    send(32'h55, 1'b1, 32'h55);
    check("clr_stall_valid", {32'd0, m_axis_tvalid}, 33'd1);
    m_axis_tready = 1'b1;
    clr_stats     = 1'b1;
    tick();
    clr_stats = 1'b0;
    check("clr_wins_pkt", {1'b0, pkt_count}, 33'd0);

    // Clamp coinciding with clr_stats: flag ends clear, data still clamped
    mode = 2'd3; add_value = 32'h10;
    send(32'hFFFF_FFF8, 1'b1, 32'hFFFF_FFFF);
    drain();
    check("sat_set_again", {32'd0, sat_flag}, 33'd1);
    clr_stats = 1'b1;
    send(32'hFFFF_FFF8, 1'b1, 32'hFFFF_FFFF);
    clr_stats = 1'b0;
    check("clr_wins_sat", {32'd0, sat_flag}, 33'd0);
    drain();

    // Reset mid-packet with a stalled output beat
    mode = 2'd1; add_value = 32'h5;
    m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'h1;
    s_axis_tlast  = 1'b0;
    tick();
    s_axis_tvalid = 1'b0;
    check("pre_rst_valid", {32'd0, m_axis_tvalid}, 33'd1);
    #2 s_axi_aresetn = 1'b0;
    #1;
    check("async_rst_valid", {32'd0, m_axis_tvalid}, 33'd0);
    check("async_rst_ready", {32'd0, s_axis_tready}, 33'd1);
    tick();
    s_axi_aresetn = 1'b1;
    add_value     = 32'h100;
    m_axis_tready = 1'b1;
    tick();
    send(32'h20, 1'b1, 32'h120);
    drain();
    check("post_rst_pkt_count", {1'b0, pkt_count}, 33'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_axis_stream_proc
`default_nettype wire

// File: doc/axis_stream_proc.md
Name: axis_stream_proc

Overview:
- AXI-Stream datapath stage directly downstream of the AXI-Lite control block; consumes its mode[1:0] and add_value outputs.
- Transforms each input beat per the selected operation and forwards it on a registered AXI-Stream master.
- Holds mode and operand constant for a whole packet, so register writes never tear a packet.
- Keeps packet and saturation statistics for software.

Parameters:
- DATA_WIDTH, 32, width of tdata, add_value and pkt_count.

Ports:
- s_axi_aclk  in  1  single clock, shared with the control block.
- s_axi_aresetn  in  1  reset, asynchronous, active-low.
- mode  in  2  operation select from the control block.
- add_value  in  DATA_WIDTH  operand from the control block.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input ready.
- s_axis_tdata  in  DATA_WIDTH  input data.
- s_axis_tlast  in  1  input end of packet.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  DATA_WIDTH  transformed data.
- m_axis_tlast  out  1  output end of packet.
- clr_stats  in  1  one-cycle pulse; clears the statistics.
- pkt_count  out  DATA_WIDTH  packets completed on the output.
- sat_flag  out  1  sticky; set when a mode-3 beat clamped.

Behaviour:
- Reset (async assert, sync release): every output is 0 except s_axis_tready=1.
  - Internal state resets to IDLE; skid buffer is empty.
- Input accept condition: s_axis_tvalid && s_axis_tready.
- Output transfer condition: m_axis_tvalid && m_axis_tready.
- Packet FSM, states IDLE and IN_PKT:
  - IDLE: on an accepted beat, latch mode and add_value into mode_q and op_q. If tlast=0, go to IN_PKT; otherwise stay in IDLE.
  - The first beat of a packet uses the live mode/add_value, i.e. the same values being latched.
  - IN_PKT: use mode_q and op_q. An accepted beat with tlast=1 returns to IDLE.
  - Changes on mode/add_value during IN_PKT take effect at the next packet start.
- Operations, result is DATA_WIDTH bits:
  - Mode 0: pass tdata unchanged.
  - Mode 1: tdata+op, modulo 2^DATA_WIDTH; carry discarded, no flag.
  - Mode 2: bitwise ~tdata; op ignored.
  - Mode 3: unsigned saturating add. If a carry out occurs, output all-ones and set sat_flag.
- Pipeline:
  - Registered output stage plus a one-entry skid buffer.
  - Latency is 1 cycle from input accept to m_axis_tvalid when the output register is empty.
  - Full throughput: one beat per cycle while m_axis_tready=1.
  - s_axis_tready is the registered value !skid_valid, with no combinational path from m_axis_tready.
- Backpressure:
  - While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata and m_axis_tlast are held stable.
  - An accepted beat with the output register full goes to the skid buffer; s_axis_tready drops the next cycle.
  - On an output transfer, skid contents move to the output register and s_axis_tready rises the next cycle.
- Beat ordering and tlast are preserved exactly; no beats are dropped or duplicated.
- pkt_count:
  - Increments on an output transfer with m_axis_tlast=1.
  - Wraps from all-ones to 0.
- sat_flag:
  - Set when a beat that clamped is accepted.
  - Stays set until clr_stats.
- clr_stats:
  - Sets pkt_count to 0 and clears sat_flag.
  - If an increment or set occurs in the same cycle, clear wins.
  - Has no effect on the datapath or the FSM.
- Reset mid-packet: in-flight beats are discarded and the FSM returns to IDLE. The next accepted beat is treated as a packet start.
- A single-beat packet (first beat has tlast=1) stays in IDLE and counts as one packet.

Decomposition:
- Shared package axis_proc_pkg:
  - Mode constants MODE_PASS=0, MODE_ADD=1, MODE_INV=2, MODE_SATADD=3.
  - FSM state encoding ST_IDLE and ST_IN_PKT.
- Sub-module axis_skid_buf, parameterised by DATA_WIDTH+1 for data plus last:
  - Provides the output register and skid buffer with the registered-ready contract.
  - Reusable by later stream stages.

Test Plan:
- Mode 0, packet of 4 beats 0x1,0x2,0x3,0x4 (last on beat 4), m_axis_tready=1 -> same data out 1 cycle after each accept, tlast on the 4th beat, pkt_count=1.
- Mode 1, add_value=0x10, input 0xFFFFFFF8 -> output 0x00000008 (wraps), sat_flag stays 0. Mode 3, same input -> output 0xFFFFFFFF, sat_flag=1.
- Mode change mid-packet: start a 3-beat packet in mode 2 with data 0x0F0F0F0F, switch mode to 0 after beat 1 -> all 3 outputs 0xF0F0F0F0; the next packet passes unchanged.
- Backpressure: stream 8 beats, m_axis_tready toggling 1,0,0,1 repeating -> all 8 beats in order, data stable while stalled, s_axis_tready low only while the skid buffer is full, no loss.
- clr_stats in the same cycle as an output tlast transfer with pkt_count=5 -> pkt_count=0. A mode-3 clamp in the same cycle as clr_stats -> sat_flag=0.
- Assert s_axi_aresetn low mid-packet with m_axis_tvalid=1 -> m_axis_tvalid=0 immediately (async). After release, a new beat in mode 1 uses the add_value live at that beat.
